// File: rtl/cmd_grant_scheduler_if.sv
// Handshake bundle between the per-rank command requesters, the rank-to-rank
// turnaround counter and the CMD grant scheduler on one channel.
interface cmd_grant_scheduler_if #(
    parameter int NUM_RANKS = 4
);
    localparam int RANK_W = $clog2(NUM_RANKS);

    logic [NUM_RANKS-1:0] rank_req;
    logic [NUM_RANKS-1:0] rank_cmd_issued;
    logic                 cmd_turnaround_free;
    logic                 rank_transition;
    logic [NUM_RANKS-1:0] rank_grant;
    logic                 grant_valid;
    logic [RANK_W-1:0]    grant_rank;

    // Scheduler side: consumes requests/issue pulses/free, produces grants.
    modport slave (
        input  rank_req,
        input  rank_cmd_issued,
        input  cmd_turnaround_free,
        output rank_transition,
        output rank_grant,
        output grant_valid,
        output grant_rank
    );

    // Environment side: ranks plus turnaround counter.
    modport master (
        output rank_req,
        output rank_cmd_issued,
        output cmd_turnaround_free,
        input  rank_transition,
        input  rank_grant,
        input  grant_valid,
        input  grant_rank
    );
endinterface

// File: rtl/cmd_grant_scheduler.sv
// Channel-level CMD bus arbiter. Prefers the rank that last owned the bus to
// avoid rank-to-rank turnaround penalties, caps back-to-back grants to one
// rank while others wait, and signals every owner change to the turnaround
// counter with a registered one-cycle pulse before the new grant is given.
module cmd_grant_scheduler #(
    parameter  int NUM_RANKS  = 4,
    parameter  int MAX_CONSEC = 4,
    localparam int RANK_W     = $clog2(NUM_RANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    cmd_grant_scheduler_if.slave bus
);
    localparam int                CNT_W      = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0]  CONSEC_MAX = CNT_W'(MAX_CONSEC);
    localparam logic [RANK_W-1:0] LAST_IDX   = RANK_W'(NUM_RANKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWITCH,
        WAIT_TA,
        GRANT
    } state_t;

    state_t               state_q, state_d;
    logic [RANK_W-1:0]    target_q, target_d;
    logic [RANK_W-1:0]    lastRank_q, lastRank_d;
    logic                 lastValid_q, lastValid_d;
    logic [RANK_W-1:0]    rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0]     consecCnt_q, consecCnt_d;
    logic                 transition_q, transition_d;
    logic [NUM_RANKS-1:0] grant_q, grant_d;
    logic                 grantValid_q, grantValid_d;

    logic [NUM_RANKS-1:0] lastMask;
    logic                 otherReq;
    logic                 stickyOk;
    logic [RANK_W-1:0]    rrIdx;
    logic                 rrFound;
    logic [RANK_W-1:0]    rrPick;
    logic [RANK_W-1:0]    pick;

    // Candidate selection: keep the current owner unless it hit the cap with
    // someone else waiting, otherwise scan round-robin from rrPtr_q.
    always_comb begin
        lastMask = NUM_RANKS'(1) << lastRank_q;
        otherReq = |(bus.rank_req & ~lastMask);
        stickyOk = lastValid_q && bus.rank_req[lastRank_q] &&
                   ((consecCnt_q < CONSEC_MAX) || !otherReq);
        rrPick   = rrPtr_q;
        rrFound  = 1'b0;
        rrIdx    = rrPtr_q;
        for (int i = 0; i < NUM_RANKS; i++) begin
            rrIdx = RANK_W'((int'(rrPtr_q) + i) % NUM_RANKS);
            if (!rrFound && bus.rank_req[rrIdx]) begin
                rrFound = 1'b1;
                rrPick  = rrIdx;
            end
        end
        pick = stickyOk ? lastRank_q : rrPick;
    end

    // Next-state logic; output flops are loaded from the next state so that
    // grant and transition line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        lastRank_d   = lastRank_q;
        lastValid_d  = lastValid_q;
        rrPtr_d      = rrPtr_q;
        consecCnt_d  = consecCnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.rank_req) begin
                    target_d = pick;
                    if (!lastValid_q || (pick == lastRank_q)) begin
                        state_d    = GRANT;
                        lastRank_d = pick;
                    end else begin
                        state_d = SWITCH;
                    end
                end
            end
            SWITCH: begin
                lastRank_d  = target_q;
                consecCnt_d = '0;
                state_d     = WAIT_TA;
            end
            WAIT_TA: begin
                if (!bus.rank_req[target_q]) begin
                    state_d = IDLE;
                end else if (bus.cmd_turnaround_free) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                lastValid_d = 1'b1;
                if (bus.rank_cmd_issued[target_q]) begin
                    state_d = IDLE;
                    if (consecCnt_q < CONSEC_MAX) begin
                        consecCnt_d = consecCnt_q + 1'b1;
                    end
                    rrPtr_d = (target_q == LAST_IDX) ? '0 : target_q + 1'b1;
                end else if (!bus.rank_req[target_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        transition_d = (state_d == SWITCH);
        grantValid_d = (state_d == GRANT);
        grant_d      = (state_d == GRANT) ? (NUM_RANKS'(1) << target_d) : '0;
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            lastRank_q   <= '0;
            lastValid_q  <= 1'b0;
            rrPtr_q      <= '0;
            consecCnt_q  <= '0;
            transition_q <= 1'b0;
            grant_q      <= '0;
            grantValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            lastRank_q   <= lastRank_d;
            lastValid_q  <= lastValid_d;
            rrPtr_q      <= rrPtr_d;
            consecCnt_q  <= consecCnt_d;
            transition_q <= transition_d;
            grant_q      <= grant_d;
            grantValid_q <= grantValid_d;
        end
    end

    assign bus.rank_transition = transition_q;
    assign bus.rank_grant      = grant_q;
    assign bus.grant_valid     = grantValid_q;
    assign bus.grant_rank      = target_q;

endmodule
